enc_serial_tx: RTL and testbench

- Downstream stage of the messenger's encrypter. Accepts encrypted 8-bit characters on a valid/ready interface and buffers them in a small FIFO.
- Serialises each character onto the single-bit transmitted_data line as an asynchronous-style frame: start bit, 8 data bits LSB first, optional parity, stop bit.
- Decouples the per-clock keyboard/encrypter character stream from the slower serial link.

---
 rtl/enc_serial_tx.sv | 154 +++++++++++++++
 tb/tb_enc_serial_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_serial_tx.sv
// enc_serial_tx: FIFO-buffered serial transmitter. Frame = start, 8 data bits LSB first, stop.
// Define ENC_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module enc_serial_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             in_char,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   transmitted_data,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef ENC_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_not_empty;
  logic          w_last_cyc;
  logic          w_line;
  logic [7:0]    w_head;
`ifdef ENC_SERIAL_TX_PARITY_EN
  logic          r_parity;
`endif

  // Ready comes from the registered count only, so a full FIFO never refills in the cycle it pops.
  assign w_ready     = (r_count != (AW+1)'(DEPTH));
  assign w_push      = in_valid & w_ready;
  assign w_not_empty = (r_count != '0);
  assign w_last_cyc  = (r_cyc == CW'(CLKS_PER_BIT - 1));
  assign w_head      = r_mem[r_rd_ptr];

  assign in_ready         = w_ready;
  assign fifo_count       = r_count;
  assign transmitted_data = r_tx;
  assign tx_busy          = r_busy;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= in_char;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_line       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_last_cyc) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_last_cyc && (r_bit == 3'd7)) begin
`ifdef ENC_SERIAL_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef ENC_SERIAL_TX_PARITY_EN
      S_PARITY: begin
        w_line = r_parity;
        if (w_last_cyc) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_last_cyc) begin
          // A waiting character starts immediately: no idle bit between frames.
          if (w_not_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Line and busy lag the state by one cycle, so both describe the same frame.
      r_tx    <= w_line;
      r_busy  <= (r_state != S_IDLE);
      if ((r_state == S_IDLE) || w_last_cyc) r_cyc <= '0;
      else                                   r_cyc <= r_cyc + 1'b1;
      if (r_state != S_DATA) r_bit <= '0;
      else if (w_last_cyc)   r_bit <= r_bit + 1'b1;
      if (w_pop)                                  r_shift <= w_head;
      else if ((r_state == S_DATA) && w_last_cyc) r_shift <= {1'b0, r_shift[7:1]};
    end
  end

`ifdef ENC_SERIAL_TX_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_head;
  end
`endif

endmodule

// File: tb/tb_enc_serial_tx.sv
// Bench for enc_serial_tx: frame-level model checked every cycle, a serial decoder, and directed cases.
module tb_enc_serial_tx;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef ENC_SERIAL_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       transmitted_data;
  logic       tx_busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  enc_serial_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset_n(reset_n), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .transmitted_data(transmitted_data), .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Bit i of a frame: 0 = start, 1..8 = data LSB first, then optional parity, last = stop.
  function automatic logic frame_bit(input logic [7:0] c, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return c[i-1];
`ifdef ENC_SERIAL_TX_PARITY_EN
    if (i == 9) return ^c;
`endif
    return 1'b1;
  endfunction

  // Model: a frame occupies the line for FRAME cycles starting one edge after its pop;
  // the next pop may happen FRAME edges after the previous one if a character is waiting.
  logic [7:0] m_q[$];
  int         m_last_pop = -100000;
  logic [7:0] m_char = 8'h00;
  bit         m_push = 1'b0;
  logic [7:0] m_push_char = 8'h00;

  always @(negedge clock) begin
    int   k;
    logic e_line;
    logic e_busy;
    if (!reset_n) begin
      m_q.delete();
      m_last_pop = -100000;
      m_push     = 1'b0;
      chk("rst_line", 32'(transmitted_data), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
    end else begin
      k = edge_n - m_last_pop;
      if (k >= 1 && k <= FRAME) begin
        e_line = frame_bit(m_char, (k - 1) / CPB);
        e_busy = 1'b1;
      end else begin
        e_line = 1'b1;
        e_busy = 1'b0;
      end
      if (m_q.size() > 0 && edge_n >= m_last_pop + FRAME) begin
        m_char     = m_q.pop_front();
        m_last_pop = edge_n;
      end
      if (m_push) m_q.push_back(m_push_char);
      chk("model_line", 32'(transmitted_data), 32'(e_line));
      chk("model_busy", 32'(tx_busy), 32'(e_busy));
      chk("model_count", 32'(fifo_count), 32'(m_q.size()));
      chk("model_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
      m_push      = in_valid && in_ready;
      m_push_char = in_char;
    end
  end

  // Serial decoder: sample each bit one cycle after its boundary.
  logic [7:0] rx_q[$];
  int         rx_starts[$];
  logic       rx_par[$];
  bit         rx_active = 1'b0;
  int         rx_start = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_pbit = 1'b0;
  logic       prev_line = 1'b1;

  always @(negedge clock) begin
    int k;
    int idx;
    if (!reset_n) begin
      rx_active = 1'b0;
      prev_line = 1'b1;
    end else begin
      if (!rx_active) begin
        if (prev_line && !transmitted_data) begin
          rx_active = 1'b1;
          rx_start  = edge_n;
          rx_byte   = 8'h00;
          rx_pbit   = 1'b0;
        end
      end else begin
        k = edge_n - rx_start;
        idx = k / CPB;
        if (k % CPB == 1) begin
          if (idx >= 1 && idx <= 8) rx_byte[idx-1] = transmitted_data;
          if (idx == 9) rx_pbit = transmitted_data;
        end
        if (k == FRAME - 1) begin
          rx_q.push_back(rx_byte);
          rx_starts.push_back(rx_start);
          rx_par.push_back(rx_pbit);
          rx_active = 1'b0;
        end
      end
      prev_line = transmitted_data;
    end
  end

  logic [7:0] stim_q[$];
  int first_push_edge = 0;
  int last_push_edge = 0;

  task automatic send_all();
    int  g;
    bit  first;
    first = 1'b1;
    while (stim_q.size() > 0) begin
      in_char  = stim_q.pop_front();
      in_valid = 1'b1;
      g = 0;
      @(negedge clock);
      while (!in_ready && g < 500) begin
        @(negedge clock);
        g++;
      end
      chk("send_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      if (first) first_push_edge = edge_n;
      last_push_edge = edge_n;
      first = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int g;
    g = 0;
    while (rx_q.size() < n && g < 3000) begin
      @(posedge clock);
      #1;
      g++;
    end
    chk("rx_wait", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((tx_busy || fifo_count != 0) && g < 2000) begin
      @(posedge clock);
      #1;
      g++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("idle_wait", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ls [0:63];
    logic       bs [0:63];
    logic [7:0] dec;
    int         first_low;
    int         busy_cnt;
    int         n0;
    int         b;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_line", 32'(transmitted_data), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Single character 0x5A: waveform pinned by hand.
    stim_q = '{8'h5A};
    send_all();
    for (int k = 0; k <= FRAME + 3; k++) begin
      @(negedge clock);
      ls[k] = transmitted_data;
      bs[k] = tx_busy;
    end
    first_low = -1;
    busy_cnt  = 0;
    for (int k = 0; k <= FRAME + 3; k++) begin
      if (first_low < 0 && !ls[k]) first_low = k;
      if (bs[k]) busy_cnt++;
    end
    for (int j = 0; j < 8; j++) dec[j] = ls[7 + 4*j];
    $display("txn single 0x5a push_edge=%0d first_low=%0d busy=%0d", last_push_edge, first_low, busy_cnt);
    chk("single_first_low", 32'(first_low), 32'd2);
    chk("single_start_end", 32'(ls[5]), 32'd0);
    chk("single_busy_cycles", 32'(busy_cnt), 32'(FRAME));
    chk("single_decode", 32'(dec), 32'h5A);
    chk("single_stop", 32'(ls[FRAME]), 32'd1);
    chk("single_busy_end", 32'(bs[FRAME + 2]), 32'd0);
    wait_idle();

    // Fill to full and drain back-to-back.
    b = rx_q.size();
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_all();
    chk("fill_count", 32'(fifo_count), 32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    stim_q = '{8'h06};
    send_all();
    wait_rx(b + 6);
    for (int i = 0; i < 6; i++) begin
      $display("txn fill rx[%0d]=%02h start_edge=%0d", i, rx_q[b+i], rx_starts[b+i]);
      chk("fill_data", 32'(rx_q[b+i]), 32'(i + 1));
    end
    for (int i = 0; i < 5; i++)
      chk("fill_gap", 32'(rx_starts[b+i+1] - rx_starts[b+i]), 32'(FRAME));
    wait_idle();

    // Push in the same cycle as the STOP->START pop.
    b = rx_q.size();
    stim_q = '{8'h11, 8'h22, 8'h33};
    send_all();
    n0 = first_push_edge;
    while (edge_n < n0 + FRAME) begin
      @(posedge clock);
      #1;
    end
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    stim_q = '{8'h44};
    send_all();
    $display("txn pushpop push_edge=%0d count=%0d", last_push_edge, fifo_count);
    chk("pp_edge", 32'(last_push_edge), 32'(n0 + FRAME + 1));
    chk("pp_count_after", 32'(fifo_count), 32'd2);
    wait_rx(b + 4);
    chk("pp_data0", 32'(rx_q[b]), 32'h11);
    chk("pp_data1", 32'(rx_q[b+1]), 32'h22);
    chk("pp_data2", 32'(rx_q[b+2]), 32'h33);
    chk("pp_data3", 32'(rx_q[b+3]), 32'h44);
    wait_idle();

    // Reset during data bit 3 of 0xFF with two characters queued.
    b = rx_q.size();
    stim_q = '{8'hFF, 8'h66, 8'h77};
    send_all();
    n0 = first_push_edge;
    while (edge_n < n0 + 19) begin
      @(posedge clock);
      #1;
    end
    chk("mid_busy", 32'(tx_busy), 32'd1);
    chk("mid_count", 32'(fifo_count), 32'd2);
    reset_n = 1'b0;
    #1;
    $display("txn midreset line=%0d busy=%0d count=%0d", transmitted_data, tx_busy, fifo_count);
    chk("mid_rst_line", 32'(transmitted_data), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (60) @(posedge clock);
    #1;
    chk("mid_no_tx", 32'(rx_q.size()), 32'(b));
    chk("mid_idle_busy", 32'(tx_busy), 32'd0);

    // 0x00 is an ordinary character.
    b = rx_q.size();
    stim_q = '{8'h00};
    send_all();
    wait_rx(b + 1);
    $display("txn zero rx=%02h", rx_q[b]);
    chk("zero_data", 32'(rx_q[b]), 32'h00);
    wait_idle();

`ifdef ENC_SERIAL_TX_PARITY_EN
    b = rx_q.size();
    stim_q = '{8'h07, 8'h03};
    send_all();
    wait_rx(b + 2);
    $display("txn parity rx=%02h/%0d %02h/%0d", rx_q[b], rx_par[b], rx_q[b+1], rx_par[b+1]);
    chk("par_07", 32'(rx_par[b]), 32'd1);
    chk("par_03", 32'(rx_par[b+1]), 32'd0);
    chk("par_frame_len", 32'(rx_starts[b+1] - rx_starts[b]), 32'd44);
    wait_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
